// File: rtl/sr_queue_ctrl_if.sv
// Command/response handshake bundle for sr_queue_ctrl.
// The master side issues commands; the slave side (the controller) answers.
interface sr_queue_ctrl_if #(
   parameter int TID_W  = 4,
   parameter int INFO_W = 32
) ();
   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_op;
   logic [TID_W-1:0]  cmd_tid;
   logic [INFO_W-1:0] cmd_info;
   logic              rsp_valid;
   logic [1:0]        rsp_err;
   logic [TID_W-1:0]  rsp_tid;

   modport master (
      output cmd_valid, cmd_op, cmd_tid, cmd_info,
      input  cmd_ready, rsp_valid, rsp_err, rsp_tid
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_tid, cmd_info,
      output cmd_ready, rsp_valid, rsp_err, rsp_tid
   );
endinterface

// File: rtl/sr_queue_ctrl.sv
// Command sequencer for the shift-register task queue: IDLE -> DECODE -> ISSUE -> SETTLE.
// Optional occupancy/error statistics ports are enabled by defining SR_QCTRL_STATS_EN.
module sr_queue_ctrl #(
   parameter int DEPTH  = 16,
   parameter int TID_W  = 4,
   parameter int INFO_W = 32,
   parameter int PRIO_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   sr_queue_ctrl_if.slave          cmd,
   input  logic [DEPTH-1:0]        q_empty,
   input  logic [DEPTH-1:0]        q_schden,
   input  logic [DEPTH*TID_W-1:0]  q_tid,
   input  logic [DEPTH*INFO_W-1:0] q_info,
   output logic [TID_W-1:0]        new_task_id,
   output logic [INFO_W-1:0]       new_task_info,
   output logic [DEPTH-1:0]        enqueue,
   output logic [DEPTH-1:0]        dequeue,
   output logic [DEPTH-1:0]        remove,
   output logic [DEPTH-1:0]        que_act,
   output logic [DEPTH-1:0]        que_blk
`ifdef SR_QCTRL_STATS_EN
   ,
   output logic [4:0]              occ_count,
   output logic [15:0]             err_count
`endif
);

   localparam logic [2:0] OP_NOP      = 3'd0;
   localparam logic [2:0] OP_CREATE   = 3'd1;
   localparam logic [2:0] OP_DISPATCH = 3'd2;
   localparam logic [2:0] OP_REMOVE   = 3'd3;
   localparam logic [2:0] OP_BLOCK    = 3'd4;
   localparam logic [2:0] OP_ACTIVATE = 3'd5;

   localparam logic [1:0] ERR_OK   = 2'd0;
   localparam logic [1:0] ERR_FULL = 2'd1;
   localparam logic [1:0] ERR_NF   = 2'd2;
   localparam logic [1:0] ERR_ILL  = 2'd3;

   typedef enum logic [1:0] {IDLE, DECODE, ISSUE, SETTLE} state_t;
   state_t state;

   logic [2:0]        op_q;
   logic [TID_W-1:0]  tid_q;
   logic [INFO_W-1:0] info_q;

   logic [DEPTH-1:0]  sel_hit, ge_mask, first_hot;
   logic              seen;
   logic [TID_W-1:0]  sel_tid;
   logic [1:0]        d_err;
   logic [TID_W-1:0]  d_tid;
   logic [DEPTH-1:0]  d_enq, d_deq, d_rem, d_act, d_blk;

   // Only the priority byte of each cell's info takes part in decoding.
   logic unused_info;
   assign unused_info = ^q_info;

   // Lowest matching cell: ge_mask covers it and every cell behind it, first_hot is it alone.
   always_comb begin
      sel_hit   = '0;
      ge_mask   = '0;
      first_hot = '0;
      seen      = 1'b0;
      sel_tid   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         unique case (op_q)
            OP_CREATE:   sel_hit[i] = q_empty[i] |
                                      (info_q[PRIO_W-1:0] > q_info[i*INFO_W +: PRIO_W]);
            OP_DISPATCH: sel_hit[i] = q_schden[i] & ~q_empty[i];
            default:     sel_hit[i] = ~q_empty[i] & (q_tid[i*TID_W +: TID_W] == tid_q);
         endcase
         first_hot[i] = sel_hit[i] & ~seen;
         seen         = seen | sel_hit[i];
         ge_mask[i]   = seen;
         sel_tid      = sel_tid | (q_tid[i*TID_W +: TID_W] & {TID_W{first_hot[i]}});
      end
   end

   always_comb begin
      d_err = ERR_OK;
      d_tid = tid_q;
      d_enq = '0;
      d_deq = '0;
      d_rem = '0;
      d_act = '0;
      d_blk = '0;
      unique case (op_q)
         OP_CREATE: begin
            if (!q_empty[DEPTH-1]) d_err = ERR_FULL;
            else                   d_enq = ge_mask;
         end
         OP_DISPATCH: begin
            if (!seen) begin
               d_err = ERR_NF;
               d_tid = '0;
            end else begin
               d_tid = sel_tid;
               if (first_hot[0]) d_deq = '1;
               else              d_rem = ge_mask;
            end
         end
         OP_REMOVE: begin
            if (!seen) d_err = ERR_NF;
            else       d_rem = ge_mask;
         end
         OP_BLOCK: begin
            if (!seen) d_err = ERR_NF;
            else       d_blk = first_hot;
         end
         OP_ACTIVATE: begin
            if (!seen) d_err = ERR_NF;
            else       d_act = first_hot;
         end
         default: d_err = ERR_ILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cmd.cmd_ready <= 1'b1;
         cmd.rsp_valid <= 1'b0;
         cmd.rsp_err   <= '0;
         cmd.rsp_tid   <= '0;
         op_q          <= '0;
         tid_q         <= '0;
         info_q        <= '0;
         new_task_id   <= '0;
         new_task_info <= '0;
         enqueue       <= '0;
         dequeue       <= '0;
         remove        <= '0;
         que_act       <= '0;
         que_blk       <= '0;
      end else begin
         cmd.rsp_valid <= 1'b0;
         new_task_id   <= '0;
         new_task_info <= '0;
         enqueue       <= '0;
         dequeue       <= '0;
         remove        <= '0;
         que_act       <= '0;
         que_blk       <= '0;
         unique case (state)
            IDLE: begin
               if (cmd.cmd_valid && cmd.cmd_ready) begin
                  op_q   <= cmd.cmd_op;
                  tid_q  <= cmd.cmd_tid;
                  info_q <= cmd.cmd_info;
                  if (cmd.cmd_op == OP_NOP) begin
                     cmd.rsp_valid <= 1'b1;
                     cmd.rsp_err   <= ERR_OK;
                     cmd.rsp_tid   <= '0;
                  end else begin
                     cmd.cmd_ready <= 1'b0;
                     state         <= DECODE;
                  end
               end
            end
            DECODE: begin
               cmd.rsp_err <= d_err;
               cmd.rsp_tid <= d_tid;
               if (d_err != ERR_OK) begin
                  cmd.rsp_valid <= 1'b1;
                  state         <= SETTLE;
               end else begin
                  enqueue <= d_enq;
                  dequeue <= d_deq;
                  remove  <= d_rem;
                  que_act <= d_act;
                  que_blk <= d_blk;
                  if (op_q == OP_CREATE) begin
                     new_task_id   <= tid_q;
                     new_task_info <= info_q;
                  end
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               cmd.rsp_valid <= 1'b1;
               state         <= SETTLE;
            end
            SETTLE: begin
               cmd.cmd_ready <= 1'b1;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SR_QCTRL_STATS_EN
   logic [4:0] occ_next;

   always_comb begin
      occ_next = '0;
      for (int unsigned i = 0; i < DEPTH; i++) occ_next = occ_next + {4'b0, ~q_empty[i]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_count <= '0;
         err_count <= '0;
      end else begin
         occ_count <= occ_next;
         if (cmd.rsp_valid && cmd.rsp_err != ERR_OK && err_count != '1)
            err_count <= err_count + 16'd1;
      end
   end
`endif

endmodule
